// File: rtl/register_file_if.sv
// -----------------------------------------------------------------------------
// register_file_if
// Bus bundle between the decode/writeback logic and the register file.
//   rs_addr, rt_addr : read addresses for ports A and B
//   rd_addr          : write address
//   write            : write enable, active-high
//   data_in          : write data
//   rs, rt           : read data for rs_addr / rt_addr
// Modports:
//   master : datapath side (drives addresses, write, data_in; receives rs/rt)
//   slave  : register file side
// -----------------------------------------------------------------------------
interface register_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
);
  logic [ADDR_WIDTH-1:0] rs_addr;
  logic [ADDR_WIDTH-1:0] rt_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  write;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] rs;
  logic [DATA_WIDTH-1:0] rt;

  modport master (
    output rs_addr, rt_addr, rd_addr, write, data_in,
    input  rs, rt
  );

  modport slave (
    input  rs_addr, rt_addr, rd_addr, write, data_in,
    output rs, rt
  );
endinterface

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
// General-purpose register file: 2**ADDR_WIDTH entries of DATA_WIDTH bits.
// Two combinational read ports (rs, rt), one synchronous write port (rd).
// Entry 0 is an ordinary writable register.
//
// Ports:
//   clock : system clock, state updates on the rising edge
//   reset : asynchronous, active-high; clears every entry immediately
//   bus   : register_file_if.slave (addresses, write enable, data, read data)
//
// Build option:
//   REGFILE_BYPASS_EN : when defined, a write presented in the current cycle
//                       is forwarded to any read port addressing the same
//                       entry before the clock edge (suppressed during reset).
//                       Storage behaviour is identical in both builds.
// -----------------------------------------------------------------------------
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic           clock,
  input  logic           reset,
  register_file_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rs_data;
  logic [DATA_WIDTH-1:0] rt_data;

  // Storage: asynchronous clear of every entry, at most one entry written per edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (bus.write) begin
      mem_q[bus.rd_addr] <= bus.data_in;
    end
  end

  // Read ports: zero-latency lookup, optionally with write-first forwarding
  always_comb begin
    rs_data = mem_q[bus.rs_addr];
    rt_data = mem_q[bus.rt_addr];
`ifdef REGFILE_BYPASS_EN
    // Forward only a qualified write; during reset the array reads as zero.
    if (bus.write && !reset && (bus.rd_addr == bus.rs_addr)) begin
      rs_data = bus.data_in;
    end else begin
      rs_data = mem_q[bus.rs_addr];
    end
    if (bus.write && !reset && (bus.rd_addr == bus.rt_addr)) begin
      rt_data = bus.data_in;
    end else begin
      rt_data = mem_q[bus.rt_addr];
    end
`else
    rs_data = mem_q[bus.rs_addr];
    rt_data = mem_q[bus.rt_addr];
`endif
  end

  assign bus.rs = rs_data;
  assign bus.rt = rt_data;

endmodule

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
// Directed-vector bench for register_file. A plain array model of the 64
// entries predicts the read ports; a compare process checks rs/rt against it
// on every falling clock edge, and literal expectations pin the model.
// -----------------------------------------------------------------------------
module tb_register_file;

  logic clock;
  logic reset;

  register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) bus ();

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int vectors = 0;
  int misses  = 0;
  bit checking = 1'b0;

  logic [31:0] model [64];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference contents: cleared by reset, one entry updated per qualified edge
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) model[i] = 32'h0;
    end else if (bus.write === 1'b1) begin
      model[bus.rd_addr] = bus.data_in;
    end
  end

  function automatic logic [31:0] exp_read(input logic [5:0] a);
    if (reset) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (bus.write && bus.rd_addr == a) return bus.data_in;
`endif
    return model[a];
  endfunction

  function automatic logic [31:0] pattern(input int a);
    return (32'(a) * 32'h0101_0101) ^ 32'hC300_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      misses++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison of both read ports against the model
  always @(negedge clock) begin
    if (checking) begin
      check("rs_cycle", bus.rs, exp_read(bus.rs_addr));
      check("rt_cycle", bus.rt, exp_read(bus.rt_addr));
    end
  end

  task automatic step(input logic [5:0] rsa, input logic [5:0] rta,
                      input logic [5:0] rda, input logic w, input logic [31:0] d);
    @(posedge clock);
    #1;
    bus.rs_addr = rsa;
    bus.rt_addr = rta;
    bus.rd_addr = rda;
    bus.write   = w;
    bus.data_in = d;
  endtask

  initial begin
    reset       = 1'b1;
    bus.rs_addr = 6'd0;
    bus.rt_addr = 6'd0;
    bus.rd_addr = 6'd0;
    bus.write   = 1'b0;
    bus.data_in = 32'h0;
    checking    = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1 check("reset_rs0", bus.rs, 32'h0);

    // Every address reads zero after reset
    for (int a = 0; a < 64; a++) step(6'(a), 6'(63 - a), 6'd0, 1'b0, 32'h0);

    // Basic writes and reads
    step(6'd0, 6'd0, 6'd10, 1'b1, 32'd500);
    step(6'd0, 6'd0, 6'd12, 1'b1, 32'd223);
    step(6'd10, 6'd12, 6'd0, 1'b0, 32'h0);
    #2 check("rd_10", bus.rs, 32'd500);
    check("rd_12", bus.rt, 32'd223);

    // Disabled writes leave contents alone
    repeat (3) step(6'd10, 6'd12, 6'd10, 1'b0, 32'hDEAD_BEEF);
    #2 check("nowrite_10", bus.rs, 32'd500);

    // Boundary entries and same-address reads
    step(6'd63, 6'd0, 6'd63, 1'b1, 32'hFFFF_FFFF);
    step(6'd63, 6'd0, 6'd0, 1'b1, 32'h0000_0001);
    step(6'd63, 6'd0, 6'd0, 1'b0, 32'h0);
    #2 check("rd_63", bus.rs, 32'hFFFF_FFFF);
    check("rd_0", bus.rt, 32'h0000_0001);
    step(6'd63, 6'd63, 6'd0, 1'b0, 32'h0);
    #2 check("same_rs", bus.rs, 32'hFFFF_FFFF);
    check("same_rt", bus.rt, 32'hFFFF_FFFF);

    // Write and read same address in one cycle
    step(6'd5, 6'd5, 6'd5, 1'b1, 32'd77);
`ifdef REGFILE_BYPASS_EN
    #2 check("fwd_pre_edge", bus.rs, 32'd77);
`else
    #2 check("old_pre_edge", bus.rs, 32'd0);
`endif
    step(6'd5, 6'd5, 6'd0, 1'b0, 32'h0);
    #2 check("post_edge_rs", bus.rs, 32'd77);
    check("post_edge_rt", bus.rt, 32'd77);

    // Reset mid-cycle clears immediately; writes under reset are dropped
    step(6'd63, 6'd10, 6'd0, 1'b0, 32'h0);
    #2 reset = 1'b1;
    #1 check("async_rs", bus.rs, 32'h0);
    check("async_rt", bus.rt, 32'h0);
    step(6'd7, 6'd7, 6'd7, 1'b1, 32'h0000_1234);
    step(6'd7, 6'd63, 6'd0, 1'b0, 32'h0);
    reset = 1'b0;
    #2 check("rst_write_drop", bus.rs, 32'h0);
    check("rst_stays_zero", bus.rt, 32'h0);

    // Distinct pattern into every entry, then read all back
    for (int a = 0; a < 64; a++) step(6'd0, 6'd0, 6'(a), 1'b1, pattern(a));
    for (int a = 0; a < 64; a++) step(6'(a), 6'(63 - a), 6'd0, 1'b0, 32'h0);
    step(6'd3, 6'd60, 6'd0, 1'b0, 32'h0);
    #2 check("pat_3", bus.rs, 32'hC003_0303);
    check("pat_60", bus.rt, 32'hFF3C_3C3C);

    @(negedge clock);
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
